// File: rtl/multiplexador_registrado_param.sv
// Registered N:1 multiplexer with a one-entry valid/ready output stage,
// round-robin scan mode and sticky out-of-range select detection.
module multiplexador_registrado_param #(
  parameter  int WIDTH      = 16,
  parameter  int N_ENTRADAS = 4,
  localparam int SEL_W      = (N_ENTRADAS > 2) ? $clog2(N_ENTRADAS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        modo,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            saida,
  output logic [SEL_W-1:0]            canal,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        erro_sel
);

  localparam logic [SEL_W:0]   N_EXT   = (SEL_W + 1)'(N_ENTRADAS);
  localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_ENTRADAS - 1);

  logic [WIDTH-1:0] chan_s [N_ENTRADAS];
  logic [SEL_W-1:0] rr_r;
  logic [SEL_W-1:0] idx_s;
  logic [WIDTH-1:0] data_s;
  logic             in_range_s;
  logic             accept_s;

  for (genvar k = 0; k < N_ENTRADAS; k++) begin : g_chan
    assign chan_s[k] = entradas[k*WIDTH +: WIDTH];
  end

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;

  // Pick the channel index for this cycle and fetch its data (zero when out of range).
  always_comb begin
    idx_s      = sel;
    data_s     = '0;
    in_range_s = 1'b0;
    if (modo) begin
      idx_s = rr_r;
    end else begin
      idx_s = sel;
    end
    in_range_s = ({1'b0, idx_s} < N_EXT);
    if (in_range_s) begin
      data_s = chan_s[idx_s];
    end else begin
      data_s = '0;
    end
  end

  // Output stage, round-robin pointer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      saida     <= '0;
      canal     <= '0;
      out_valid <= 1'b0;
      erro_sel  <= 1'b0;
      rr_r      <= '0;
    end else if (accept_s) begin
      saida     <= data_s;
      canal     <= idx_s;
      out_valid <= 1'b1;
      if (!modo && !in_range_s) begin
        erro_sel <= 1'b1;
      end
      // rr only moves on accepted words taken in scan mode
      if (modo) begin
        rr_r <= (rr_r == RR_LAST) ? '0 : rr_r + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplexador_registrado_param.sv
// Directed + random bench for multiplexador_registrado_param, running a 4-input
// and a 3-input instance side by side against a queue-based reference model.
module tb_multiplexador_registrado_param;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  c;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ch [4];
  logic [1:0]  sel;
  logic        modo, in_valid, out_ready;

  logic [63:0] entradas4;
  logic [47:0] entradas3;
  logic        in_ready4, out_valid4, erro4, in_ready3, out_valid3, erro3;
  logic [15:0] saida4, saida3;
  logic [1:0]  canal4, canal3;

  exp_t        q4[$], q3[$];
  logic [1:0]  rr4, rr3;
  logic        err4, err3;
  logic [15:0] last_d4, last_d3;
  logic [1:0]  last_c4, last_c3;
  int          n_cmp = 0;
  int          n_err = 0;

  assign entradas4 = {ch[3], ch[2], ch[1], ch[0]};
  assign entradas3 = {ch[2], ch[1], ch[0]};

  always #5 clk = ~clk;

  multiplexador_registrado_param #(.WIDTH(16), .N_ENTRADAS(4)) dut4 (
    .clk(clk), .rst(rst), .entradas(entradas4), .sel(sel), .modo(modo),
    .in_valid(in_valid), .in_ready(in_ready4), .saida(saida4), .canal(canal4),
    .out_valid(out_valid4), .out_ready(out_ready), .erro_sel(erro4)
  );

  multiplexador_registrado_param #(.WIDTH(16), .N_ENTRADAS(3)) dut3 (
    .clk(clk), .rst(rst), .entradas(entradas3), .sel(sel), .modo(modo),
    .in_valid(in_valid), .in_ready(in_ready3), .saida(saida3), .canal(canal3),
    .out_valid(out_valid3), .out_ready(out_ready), .erro_sel(erro3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t expect_word(input int n, input logic [1:0] r);
    exp_t w;
    w.c = modo ? r : sel;
    w.e = !modo && (int'(w.c) >= n);
    w.d = (int'(w.c) < n) ? ch[w.c] : 16'h0000;
    return w;
  endfunction

  function automatic logic [1:0] rr_next(input int n, input logic [1:0] r);
    return (int'(r) == n - 1) ? 2'd0 : r + 2'd1;
  endfunction

  // One clock: predict, check handshake, advance, check registered outputs.
  task automatic cyc();
    logic rdy4, rdy3, acc4, acc3;
    exp_t w4, w3;
    #1;
    rdy4 = !rst && (q4.size() == 0 || out_ready);
    rdy3 = !rst && (q3.size() == 0 || out_ready);
    chk("in_ready4", {63'd0, in_ready4}, {63'd0, rdy4});
    chk("in_ready3", {63'd0, in_ready3}, {63'd0, rdy3});
    acc4 = in_valid && rdy4;
    acc3 = in_valid && rdy3;
    w4 = expect_word(4, rr4);
    w3 = expect_word(3, rr3);
    if (rst) begin
      q4.delete(); q3.delete();
      rr4 = 2'd0; rr3 = 2'd0; err4 = 1'b0; err3 = 1'b0;
      last_d4 = 16'h0000; last_d3 = 16'h0000; last_c4 = 2'd0; last_c3 = 2'd0;
    end else begin
      if (q4.size() > 0 && out_ready) void'(q4.pop_front());
      if (q3.size() > 0 && out_ready) void'(q3.pop_front());
      if (acc4) begin
        q4.push_back(w4); err4 |= w4.e; last_d4 = w4.d; last_c4 = w4.c;
        if (modo) rr4 = rr_next(4, rr4);
      end
      if (acc3) begin
        q3.push_back(w3); err3 |= w3.e; last_d3 = w3.d; last_c3 = w3.c;
        if (modo) rr3 = rr_next(3, rr3);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid4", {63'd0, out_valid4}, {63'd0, q4.size() > 0});
    chk("out_valid3", {63'd0, out_valid3}, {63'd0, q3.size() > 0});
    chk("saida4", {48'd0, saida4}, {48'd0, last_d4});
    chk("canal4", {62'd0, canal4}, {62'd0, last_c4});
    chk("saida3", {48'd0, saida3}, {48'd0, last_d3});
    chk("canal3", {62'd0, canal3}, {62'd0, last_c3});
    chk("erro_sel4", {63'd0, erro4}, {63'd0, err4});
    chk("erro_sel3", {63'd0, erro3}, {63'd0, err3});
  endtask

  initial begin
    rr4 = 2'd0; rr3 = 2'd0; err4 = 1'b0; err3 = 1'b0;
    last_d4 = 16'h0000; last_d3 = 16'h0000; last_c4 = 2'd0; last_c3 = 2'd0;
    rst = 1'b1; modo = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0;
    ch[0] = 16'h1111; ch[1] = 16'h2222; ch[2] = 16'h3333; ch[3] = 16'h4444;
    @(posedge clk);
    cyc(); cyc();

    // direct select following sel with one-cycle latency
    rst = 1'b0; in_valid = 1'b1; sel = 2'd2;
    cyc();
    chk("first_word", {48'd0, saida4}, 64'h3333);
    sel = 2'd0; cyc();
    sel = 2'd1; cyc();
    sel = 2'd3; cyc();   // out of range for the 3-input instance
    chk("err3_set", {63'd0, erro3}, 64'd1);
    chk("oor_zero", {48'd0, saida3}, 64'h0);
    sel = 2'd1; cyc();   // in range again, error stays sticky
    chk("err3_sticky", {63'd0, erro3}, 64'd1);

    // backpressure
    sel = 2'd0; cyc();
    out_ready = 1'b0; sel = 2'd1; ch[0] = 16'hAAAA;
    cyc(); cyc(); cyc();
    chk("stall_hold", {48'd0, saida4}, 64'h1111);
    out_ready = 1'b1; cyc();
    chk("resume_word", {48'd0, saida4}, 64'h2222);
    in_valid = 1'b0; cyc();   // consume without accept
    cyc();

    // round-robin from reset
    rst = 1'b1; cyc();
    rst = 1'b0; modo = 1'b1; in_valid = 1'b1; sel = 2'd3;
    for (int i = 0; i < 6; i++) cyc();
    in_valid = 1'b1; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; cyc();

    // mode switch retention
    rst = 1'b1; cyc();
    rst = 1'b0; modo = 1'b1; in_valid = 1'b1;
    cyc(); cyc();
    modo = 1'b0; sel = 2'd0; cyc(); sel = 2'd1; cyc(); sel = 2'd3; cyc();
    modo = 1'b1; cyc();
    chk("rr_resume", {62'd0, canal4}, 64'd2);

    // reset in the middle of a stall
    out_ready = 1'b0; cyc(); cyc();
    rst = 1'b1; cyc(); cyc();
    chk("rst_valid", {63'd0, out_valid4}, 64'd0);
    rst = 1'b0; out_ready = 1'b1;

    // random traffic
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      modo      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) ch[k] = 16'($urandom);
      rst       = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplexador_registrado_param.md
Name: multiplexador_registrado_param

Overview:
Parametrised registered N:1 multiplexer for the datapath (bloco operativo), replacing the fixed 4×16-bit registered mux at every datapath site. Adds a one-entry valid/ready output stage, a round-robin scan mode, out-of-range select detection and a synchronous reset. Source-side selection is registered together with the data, so downstream logic sees which channel each word came from.

Parameters:
WIDTH, 16, data width of each input and of saida (1..64)
N_ENTRADAS, 4, number of input channels (2..16)
SEL_W, derived local = max(1, clog2(N_ENTRADAS)), width of sel/canal (not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
entradas  input  N_ENTRADAS*WIDTH  flattened inputs; channel k = entradas[k*WIDTH +: WIDTH]
sel  input  SEL_W  channel select, used in modo=0
modo  input  1  0 = direct select, 1 = round-robin scan
in_valid  input  1  upstream offers a transfer this cycle
in_ready  output  1  block accepts a transfer this cycle
saida  output  WIDTH  registered selected data
canal  output  SEL_W  channel index that produced saida
out_valid  output  1  saida/canal hold an unconsumed word
out_ready  input  1  downstream consumes the word this cycle
erro_sel  output  1  sticky: an out-of-range sel was accepted

Behaviour:
- Reset (rst=1 at posedge): saida=0, canal=0, out_valid=0, erro_sel=0, round-robin pointer rr=0. While rst=1, in_ready=0 (no transfers accepted).
- in_ready = !rst && (!out_valid || out_ready); combinational, no dependence on in_valid.
- Accept = in_valid && in_ready. On accept: saida <= selected channel, canal <= chosen index, out_valid <= 1. Latency exactly 1 cycle input→saida.
- Consume without accept (out_valid && out_ready && !accept): out_valid <= 0; saida/canal keep their last values.
- Simultaneous consume + accept: new word replaces old, out_valid stays 1; sustained throughput one word per cycle.
- Stall (out_valid && !out_ready): saida, canal, out_valid stable; in_ready=0; rr does not advance.
- modo=0: chosen index = sel. If sel >= N_ENTRADAS on accept: saida <= 0, canal <= sel, erro_sel <= 1 (sticky until rst). In-range sel never clears erro_sel.
- modo=1: chosen index = rr, sel ignored, never sets erro_sel. On each accept rr <= (rr == N_ENTRADAS-1) ? 0 : rr+1. rr unchanged when no accept.
- Mode switch: modo sampled per cycle; rr retained while modo=0 and resumes from its held value on return to modo=1.
- Non-power-of-two N_ENTRADAS: rr wraps at N_ENTRADAS-1, never reaches unused codes.
- Reset mid-operation: pending output word discarded (out_valid=0 next cycle) regardless of out_ready.
- Data inputs are sampled only on accept; changes to entradas at other times have no effect.

Test Plan:
- Reset then direct select: rst 1 cycle, modo=0, ch0..3=0x1111/0x2222/0x3333/0x4444, sel=2, in_valid=1, out_ready=1 -> next cycle saida=0x3333, canal=2, out_valid=1; every cycle after follows sel with 1-cycle latency.
- Backpressure: out_ready=0 after first accept of 0x1111 (sel=0), change sel/entradas -> saida stays 0x1111, in_ready=0 until out_ready=1; then next word captured in that cycle, out_valid never drops.
- Round-robin: modo=1, in_valid=1, out_ready=1, 6 cycles -> canal sequence 0,1,2,3,0,1 with matching data; with in_valid toggled 1,0,1, canal advances only on accepts.
- Out-of-range: N_ENTRADAS=3, SEL_W=2, modo=0, sel=3 accepted -> saida=0, canal=3, erro_sel=1; subsequent sel=1 -> normal data, erro_sel still 1 until rst.
- Mode switch retention: modo=1 for 2 accepts (rr=2), modo=0 for 3 accepts, modo=1 -> first canal=2.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst -> next cycle out_valid=0, saida=0, erro_sel=0, rr=0, in_ready=0 while rst high.
